// File: rtl/stw_controller.sv
// Self-test walker: broadcasts four fixed multiply-add vectors to the PE array,
// waits for each PE to run them, and accumulates a sticky per-PE fault map.
module stw_controller #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE    = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_req,
  input  logic [NUM_PE-1:0]    STW_complete,
  input  logic [NUM_PE-1:0]    STW_result_out,
  output logic                 STW_test_load_en,
  output logic [WORD_SIZE-1:0] STW_mult_op1,
  output logic [WORD_SIZE-1:0] STW_mult_op2,
  output logic [WORD_SIZE-1:0] STW_add_op,
  output logic [WORD_SIZE-1:0] STW_expected,
  output logic                 STW_start,
  output logic                 test_busy,
  output logic                 test_done,
  output logic [NUM_PE-1:0]    fault_map,
  output logic                 fault_any,
  output logic [1:0]           vector_idx
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WORD_SIZE-1:0] ONES = '1;
  localparam logic [WORD_SIZE-1:0] ALT  = WORD_SIZE'({WORD_SIZE{2'b01}});

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_LOW, S_WAIT_HIGH, S_CHECK, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           vec_q, vec_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d, wait_inc;
  logic [NUM_PE-1:0]    fault_q, fault_d;
  logic                 load_en_q, load_en_d, start_q, start_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [WORD_SIZE-1:0] op1_q, op1_d, op2_q, op2_d, add_q, add_d, exp_q, exp_d;

  assign wait_inc = wait_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: if (test_req) begin
        fault_d = '0;
        vec_d   = 2'd0;
        state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        wait_cnt_d = wait_inc;
        if (STW_complete == '0) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT_HIGH;
        end else if (wait_inc == CW'(TIMEOUT)) begin
          // PEs that never dropped complete are the ones that ignored start
          fault_d = fault_q | STW_complete;
          state_d = S_CHECK;
        end
      end
      S_WAIT_HIGH: begin
        wait_cnt_d = wait_inc;
        if (&STW_complete) begin
          state_d = S_CHECK;
        end else if (wait_inc == CW'(TIMEOUT)) begin
          fault_d = fault_q | ~STW_complete;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        fault_d = fault_q | ~STW_result_out;
        if (vec_q == 2'd3) state_d = S_DONE;
        else begin
          vec_d   = vec_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes and vector registers follow the next state so they line up with it
    load_en_d = (state_d == S_LOAD);
    start_d   = (state_d == S_START);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);

    op1_d = op1_q;
    op2_d = op2_q;
    add_d = add_q;
    if (state_d == S_LOAD) begin
      case (vec_d)
        2'd0:    begin op1_d = WORD_SIZE'(1); op2_d = WORD_SIZE'(1); add_d = '0;             end
        2'd1:    begin op1_d = ONES;          op2_d = WORD_SIZE'(1); add_d = WORD_SIZE'(1);  end
        2'd2:    begin op1_d = ALT;           op2_d = WORD_SIZE'(2); add_d = '0;             end
        default: begin op1_d = WORD_SIZE'(3); op2_d = WORD_SIZE'(5); add_d = ONES;           end
      endcase
    end
    exp_d = op1_d * op2_d + add_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      wait_cnt_q <= '0;
      fault_q    <= '0;
      load_en_q  <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      add_q      <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      load_en_q  <= load_en_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      add_q      <= add_d;
      exp_q      <= exp_d;
    end
  end

  assign STW_test_load_en = load_en_q;
  assign STW_start        = start_q;
  assign STW_mult_op1     = op1_q;
  assign STW_mult_op2     = op2_q;
  assign STW_add_op       = add_q;
  assign STW_expected     = exp_q;
  assign test_busy        = busy_q;
  assign test_done        = done_q;
  assign fault_map        = fault_q;
  assign fault_any        = |fault_q;
  assign vector_idx       = vec_q;

endmodule

// File: tb/tb_stw_controller.sv
// Randomized scoreboard bench for stw_controller with behavioural PE models.
module tb_stw_controller;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst, test_req;
  logic [N-1:0] complete, result;
  logic         load_en, start, busy, done, f_any;
  logic [W-1:0] op1, op2, addo, expo;
  logic [N-1:0] fmap;
  logic [1:0]   vidx;

  stw_controller #(.WORD_SIZE(W), .NUM_PE(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .test_req(test_req),
    .STW_complete(complete), .STW_result_out(result),
    .STW_test_load_en(load_en), .STW_mult_op1(op1), .STW_mult_op2(op2),
    .STW_add_op(addo), .STW_expected(expo), .STW_start(start),
    .test_busy(busy), .test_done(done), .fault_map(fmap),
    .fault_any(f_any), .vector_idx(vidx));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PE array model: complete low for lat[i] cycles after start, then high
  int           lat [N];
  logic [N-1:0] stuck1, stuck0;
  logic [N-1:0] fail_mask [4];
  logic [N-1:0] pe_c;
  int           pe_cnt [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_c <= '1;
      for (int i = 0; i < N; i++) pe_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (start) begin
          pe_c[i]   <= 1'b0;
          pe_cnt[i] <= lat[i];
        end else if (pe_cnt[i] > 0) begin
          pe_cnt[i] <= pe_cnt[i] - 1;
          if (pe_cnt[i] == 1) pe_c[i] <= 1'b1;
        end
      end
    end
  end
  assign complete = (pe_c | stuck1) & ~stuck0;
  assign result   = ~fail_mask[vidx];

  typedef struct {
    bit           is_done;
    int           cyc;
    logic [1:0]   idx;
    logic [W-1:0] op1, op2, add, expv;
    logic [N-1:0] fm;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] VOP1 [4] = '{16'h0001, 16'hFFFF, 16'h5555, 16'h0003};
  logic [W-1:0] VOP2 [4] = '{16'h0001, 16'h0001, 16'h0002, 16'h0005};
  logic [W-1:0] VADD [4] = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF};
  logic [W-1:0] VEXP [4] = '{16'h0001, 16'h0000, 16'hAAAA, 16'h000E};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: what the PE array shows in cycle t for a start in cycle s
  function automatic logic [N-1:0] pe_at(input int s, input int t);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = stuck0[i] ? 1'b0 : stuck1[i] ? 1'b1 : (t > s + lat[i]);
    return r;
  endfunction

  // Expected campaign for test_req sampled in cycle c
  task automatic push_campaign(input int c, output int done_cyc, output logic [N-1:0] fm_out);
    logic [N-1:0] fm, cv, off;
    int t, s;
    bit timed;
    exp_t e;
    fm = '0;
    t  = c + 1;
    for (int v = 0; v < 4; v++) begin
      e = '{is_done: 1'b0, cyc: t, idx: 2'(v), op1: VOP1[v], op2: VOP2[v],
            add: VADD[v], expv: VEXP[v], fm: fm};
      sbq.push_back(e);
      s = t + 1;
      t = s + 1;
      off = '0;
      timed = 1'b0;
      for (int k = 0; k < TO; k++) begin
        cv = pe_at(s, t);
        t++;
        if (cv == '0) break;
        if (k == TO - 1) begin off = cv; timed = 1'b1; end
      end
      if (!timed)
        for (int k = 0; k < TO; k++) begin
          cv = pe_at(s, t);
          t++;
          if (&cv) break;
          if (k == TO - 1) off = ~cv;
        end
      fm = fm | off | fail_mask[v];
      t++;
    end
    e = '{is_done: 1'b1, cyc: t, idx: 2'd3, op1: '0, op2: '0, add: '0, expv: '0, fm: fm};
    sbq.push_back(e);
    done_cyc = t;
    fm_out   = fm;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents load_en or test_done
  int n_load = 0, n_start = 0;
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("fault_any", 64'(f_any), 64'(|fmap));
      if (start) begin
        n_start++;
        chk("start_after_load", 64'(prev_load), 64'd1);
      end
      if (load_en) begin
        n_load++;
        if (sbq.size() == 0 || sbq[0].is_done) begin
          chk("unexpected_load", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("load_cycle", 64'(cyc), 64'(e.cyc));
          chk("load_idx", 64'(vidx), 64'(e.idx));
          chk("load_vector", {op1, op2, addo, expo}, {e.op1, e.op2, e.add, e.expv});
          chk("load_fault_map", 64'(fmap), 64'(e.fm));
          chk("load_busy", 64'(busy), 64'd1);
        end
      end
      if (done) begin
        if (sbq.size() == 0 || !sbq[0].is_done) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("done_fault_map", 64'(fmap), 64'(e.fm));
        end
      end
      prev_load = load_en;
    end else prev_load = 1'b0;
  end

  task automatic set_pes(input int l, input logic [N-1:0] s1, input logic [N-1:0] s0);
    for (int i = 0; i < N; i++) lat[i] = l;
    stuck1 = s1;
    stuck0 = s0;
    for (int v = 0; v < 4; v++) fail_mask[v] = '0;
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    c = cyc;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {load_en, start, busy, done, f_any, vidx, fmap, op1, op2, addo, expo}, 64'd0);
  endtask

  // Full campaign with a one-cycle test_req pulse, then a sticky check
  task automatic run_campaign(input string tag);
    int c, d;
    logic [N-1:0] fm;
    wait_idle(c);
    push_campaign(c, d, fm);
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk({tag, "_sticky_fm"}, 64'(fmap), 64'(fm));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int c, d, d2, nl, ns;
    logic [N-1:0] fm;
    rst = 1'b1;
    test_req = 1'b0;
    set_pes(2, '0, '0);
    #1;
    check_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle_after_reset");

    // All compliant and passing
    nl = n_load; ns = n_start;
    run_campaign("pass");
    chk("load_pulses", 64'(n_load - nl), 64'd4);
    chk("start_pulses", 64'(n_start - ns), 64'd4);
    chk("pass_fm", 64'(fmap), 64'd0);

    // PE2 fails v1 only, then a clean campaign clears the map
    set_pes(2, '0, '0);
    fail_mask[1] = 4'b0100;
    run_campaign("pe2_v1");
    chk("pe2_fault_any", 64'(f_any), 64'd1);
    set_pes(2, '0, '0);
    run_campaign("clear");
    chk("clear_fm", 64'(fmap), 64'd0);

    // PE1 complete stuck high; other PEs busy past the timeout
    set_pes(20, 4'b0010, '0);
    run_campaign("pe1_stuck1");
    chk("pe1_stuck_fm", 64'(fmap), 64'b0010);

    // PE3 complete stuck low: WAIT_HIGH timeout
    set_pes(2, '0, 4'b1000);
    run_campaign("pe3_stuck0");

    // test_req held high: back-to-back campaigns, second from IDLE after DONE
    set_pes(2, '0, '0);
    wait_idle(c);
    push_campaign(c, d, fm);
    push_campaign(d + 1, d2, fm);
    chk("held_gap", 64'(d2 - d), 64'd26);
    test_req = 1'b1;
    while (cyc < d2 && cyc < c + 200) @(negedge clk);
    test_req = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("held_idle", 64'(busy), 64'd0);

    // test_req pulsed during WAIT_HIGH of v0 is ignored
    set_pes(2, '0, '0);
    wait_idle(c);
    push_campaign(c, d, fm);
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    while (cyc < c + 4) @(negedge clk);
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    wait_drain();
    repeat (30) @(negedge clk);
    chk("pulse_ignored_idle", 64'(busy), 64'd0);

    // Reset during WAIT_HIGH of v2 aborts without test_done
    set_pes(2, '0, '0);
    fail_mask[0] = 4'b0001;
    wait_idle(c);
    push_campaign(c, d, fm);
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    while (cyc < c + 16) @(negedge clk);
    chk("pre_abort_idx", 64'(vidx), 64'd2);
    rst = 1'b1;
    #1;
    check_zero("abort_outputs");
    sbq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_zero("abort_stays_idle");
    set_pes(2, '0, '0);
    run_campaign("post_abort");

    // Randomized PE latencies, failures and stuck lines
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 5);
      stuck1 = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      stuck0 = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) & ~stuck1 : '0;
      for (int v = 0; v < 4; v++)
        fail_mask[v] = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      run_campaign("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/stw_controller.md
STW_CONTROLLER -- requirements
Module: stw_controller

Interface
REQ-001 Parameter WORD_SIZE, default 16, operand/result width; SHALL be >= 4.
REQ-002 Parameter NUM_PE, default 4, number of PEs served; SHALL be >= 1.
REQ-003 Parameter TIMEOUT, default 16, maximum wait cycles per wait state.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 test_req  in  1  start a self-test campaign when sampled high in IDLE.
REQ-007 STW_complete  in  NUM_PE  per-PE test-complete, high when the PE is idle.
REQ-008 STW_result_out  in  NUM_PE  per-PE pass flag, 1 = pass.
REQ-009 STW_test_load_en  out  1  vector load strobe to all PEs.
REQ-010 STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected  out  WORD_SIZE each  broadcast test vector.
REQ-011 STW_start  out  1  test start strobe to all PEs.
REQ-012 test_busy  out  1  high in every state except IDLE.
REQ-013 test_done  out  1  one-cycle pulse at campaign end.
REQ-014 fault_map  out  NUM_PE  sticky per-PE fault flags, 1 = faulty.
REQ-015 fault_any  out  1  OR-reduction of fault_map.
REQ-016 vector_idx  out  2  index of the current vector.

Function
REQ-017 All outputs SHALL be registered, except fault_any, which is combinational from fault_map.
REQ-018 States SHALL be IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH, CHECK, DONE.
REQ-019 IDLE with test_req=1: SHALL clear fault_map, set vector_idx=0 and go to LOAD; test_req in any other state SHALL be ignored.
REQ-020 LOAD: STW_test_load_en=1 for exactly that cycle, operands per REQ-021; next state START.
REQ-021 Vectors SHALL be fixed (ones = all bits 1, alt = alternating 01 pattern, 0x5555 at WORD_SIZE=16):
- v0: op1=1, op2=1, add=0
- v1: op1=ones, op2=1, add=1
- v2: op1=alt, op2=2, add=0
- v3: op1=3, op2=5, add=ones
REQ-022 STW_expected SHALL equal (op1*op2 + add) mod 2^WORD_SIZE. At WORD_SIZE=16 the expected values are v0=0x0001, v1=0x0000, v2=0xAAAA, v3=0x000E.
REQ-023 The operand and expected outputs SHALL hold stable from LOAD through CHECK.
REQ-024 START: STW_start=1 for exactly one cycle; next state WAIT_LOW; the wait counter SHALL clear.
REQ-025 WAIT_LOW SHALL exit to WAIT_HIGH when STW_complete is all zeros.
REQ-026 WAIT_HIGH SHALL exit to CHECK when STW_complete is all ones.
REQ-027 Each wait state SHALL increment the wait counter per cycle, and the counter SHALL clear on every entry to a wait state.
REQ-028 If the wait counter reaches TIMEOUT, the controller SHALL OR the offending PEs into fault_map and go to CHECK:
- in WAIT_LOW, offenders are bits still high;
- in WAIT_HIGH, offenders are bits still low.
REQ-029 CHECK: fault_map <= fault_map | ~STW_result_out.
REQ-030 After CHECK: if vector_idx<3, increment vector_idx and go to LOAD; if vector_idx=3, go to DONE.
REQ-031 DONE: test_done=1 for one cycle, then go to IDLE.
REQ-032 fault_map SHALL hold its value until the next accepted test_req or reset.
REQ-033 With compliant PEs (complete drops 1 cycle after start, rises 2 cycles later), each vector SHALL take 6 cycles.
REQ-034 If test_req is sampled in IDLE in cycle c, test_done SHALL be high in cycle c+25.
REQ-035 test_req high in the DONE cycle SHALL be ignored; a new campaign SHALL need test_req in a later IDLE cycle.

Reset
REQ-036 rst SHALL asynchronously force:
- state IDLE;
- all strobes, test_busy, test_done, fault_map, vector_idx, wait counter to 0;
- operand and expected outputs to 0.
REQ-037 rst asserted mid-campaign SHALL abort the campaign with no test_done pulse; after release the controller SHALL wait in IDLE for test_req.

Verification
REQ-038 NUM_PE=4 compliant PE models, all passing, test_req pulse -> load_en/start each pulse 4 times, fault_map=0000, fault_any=0, test_done at c+25.
REQ-039 PE2 returns result=0 on v1 only -> fault_map=0100, fault_any=1, sticky through v2/v3 and after DONE; the next campaign with all passing -> fault_map=0000.
REQ-040 PE1 STW_complete stuck at 1 -> WAIT_LOW times out after 16 cycles on every vector, fault_map=0010, and the campaign still completes with test_done.
REQ-041 test_req held high throughout -> the second campaign starts only from IDLE after DONE, with no overlap; test_req pulsed during WAIT_HIGH -> ignored.
REQ-042 rst asserted during WAIT_HIGH of v2 -> all outputs 0 immediately and no test_done pulse; a subsequent test_req runs a full clean campaign.
REQ-043 At WORD_SIZE=16, check STW_expected per vector = 0x0001, 0x0000, 0xAAAA, 0x000E while load_en is high.
